img_window_ctrl: RTL and testbench

Sequencer for the image line-buffer FIFO in the CNN input path. It accepts 32-bit packed pixel words (4 × 8-bit pixels) from the upstream stream and drives the FIFO's `write_fifo` and `read_fifo` strobes. It prefills two rows plus three pixels, then issues one read per 3×3 window. Each window is tagged with its row and column position for the convolution engine, and the block signals frame completion.

---
 rtl/img_window_ctrl_pkg.sv | 11 +
 rtl/img_window_ctrl_win_pos_counter.sv | 32 +++
 rtl/img_window_ctrl.sv | 72 +++++++
 tb/tb_img_window_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/img_window_ctrl_pkg.sv
// cnn_img_pkg: shared frame geometry, prefill depth and sequencer state encoding
package cnn_img_pkg;
  localparam int ROW_PIXELS = 224;
  localparam int COL_PIXELS = 224;
  localparam int BYTES_PER_WORD = 4;
  localparam int PREFILL_PX = 2 * ROW_PIXELS + 3;
  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_e;
  function automatic int prefill_px(input int row_pixels);
    return 2 * row_pixels + 3;
  endfunction
endpackage

// File: rtl/img_window_ctrl_win_pos_counter.sv
// win_pos_counter: raster position of the 3x3 window anchor, with flat pixel index
module win_pos_counter #(
  parameter int ROW_PIXELS = cnn_img_pkg::ROW_PIXELS,
  parameter int COL_PIXELS = cnn_img_pkg::COL_PIXELS,
  parameter int PX_W = 16,
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             step,
  output logic [POS_W-1:0] col,
  output logic [POS_W-1:0] row,
  output logic [PX_W-1:0]  anchor,
  output logic             last
);
  logic col_end;
  assign col_end = col == POS_W'(ROW_PIXELS - 3);
  assign last = col_end && row == POS_W'(COL_PIXELS - 3);
  // wrapping skips the two right-edge columns, so the flat index jumps by 3
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      col <= '0;
      row <= '0;
      anchor <= '0;
    end else if (step) begin
      col <= col_end ? '0 : col + POS_W'(1);
      row <= col_end ? row + POS_W'(1) : row;
      anchor <= anchor + (col_end ? PX_W'(3) : PX_W'(1));
    end
  end
endmodule

// File: rtl/img_window_ctrl.sv
// img_window_ctrl: line-buffer FIFO sequencer, prefills two rows + 3 px then reads one 3x3 window per strobe
module img_window_ctrl #(
  parameter int ROW_PIXELS = cnn_img_pkg::ROW_PIXELS,
  parameter int COL_PIXELS = cnn_img_pkg::COL_PIXELS,
  parameter int PX_W = 16,
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             conv_ready,
  output logic             write_fifo,
  output logic             read_fifo,
  output logic             win_valid,
  output logic [POS_W-1:0] win_row,
  output logic [POS_W-1:0] win_col,
  output logic             busy,
  output logic             done
);
  import cnn_img_pkg::*;
  localparam logic [PX_W-1:0] FILL_PX = PX_W'(prefill_px(ROW_PIXELS));
  localparam logic [PX_W-1:0] TOTAL_PX = PX_W'(ROW_PIXELS * COL_PIXELS);
  localparam logic [PX_W-1:0] STEP_PX = PX_W'(BYTES_PER_WORD);
  state_e state;
  logic [PX_W-1:0] wr_px, anchor;
  logic [POS_W-1:0] row, col;
  logic last, clr;
  assign clr = state == IDLE && start;
  assign busy = state != IDLE;
  win_pos_counter #(
    .ROW_PIXELS(ROW_PIXELS), .COL_PIXELS(COL_PIXELS), .PX_W(PX_W), .POS_W(POS_W)
  ) u_pos (
    .clk(clk), .resetn(resetn), .clr(clr), .step(read_fifo),
    .col(col), .row(row), .anchor(anchor), .last(last)
  );
  // read depends only on registered counters and conv_ready, never on in_valid
  always_comb begin
    read_fifo = state == STREAM && conv_ready && wr_px >= anchor + FILL_PX;
    in_ready = state == FILL || (state == STREAM && !read_fifo && wr_px < TOTAL_PX);
    write_fifo = in_valid && in_ready;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      wr_px <= '0;
      win_valid <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      done <= 1'b0;
    end else begin
      win_valid <= read_fifo;
      win_row <= row;
      win_col <= col;
      done <= 1'b0;
      if (write_fifo) wr_px <= wr_px + STEP_PX;
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          wr_px <= '0;
        end
        FILL: if (write_fifo && wr_px + STEP_PX >= FILL_PX) state <= STREAM;
        STREAM: if (read_fifo && last) begin
          state <= FLUSH;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_img_window_ctrl.sv
// tb_img_window_ctrl: 6x6 frame checked cycle-by-cycle against a word/window-count model
module tb_img_window_ctrl;
  localparam int R = 6;
  localparam int C = 6;
  localparam int WORDS = R * C / 4;
  localparam int WINS = (R - 2) * (C - 2);
  localparam int PRE = 2 * R + 3;
  logic clk = 0, resetn = 0, start = 0, in_valid = 0, conv_ready = 0;
  logic in_ready, write_fifo, read_fifo, win_valid, busy, done;
  logic [7:0] win_row, win_col;
  int total = 0, bad = 0;
  bit running = 0, fl = 0, pv = 0;
  int n_words = 0, n_win = 0, prow = 0, pcol = 0;
  int wr_cnt, win_cnt, fill_w;
  always #5 clk = ~clk;
  img_window_ctrl #(.ROW_PIXELS(R), .COL_PIXELS(C), .PX_W(16), .POS_W(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .conv_ready(conv_ready), .write_fifo(write_fifo), .read_fifo(read_fifo),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input bit iv, input bit cr, input bit st);
    bit er, ei;
    int px, wr, wc;
    @(negedge clk);
    in_valid = iv;
    conv_ready = cr;
    start = st;
    #1;
    px = n_words * 4;
    wr = n_win / (R - 2);
    wc = n_win % (R - 2);
    er = running && px >= PRE && cr && px >= wr * R + wc + PRE;
    ei = running && (px < PRE || (!er && n_words < WORDS));
    chk("read_fifo", read_fifo, er);
    chk("in_ready", in_ready, ei);
    chk("write_fifo", write_fifo, ei && iv);
    chk("win_valid", win_valid, pv);
    chk("done", done, fl);
    chk("busy", busy, running || fl);
    if (pv) begin
      chk("win_row", win_row, prow);
      chk("win_col", win_col, pcol);
    end
    if (running) chk("anchor", dut.u_pos.anchor, wr * R + wc);
    if (write_fifo) wr_cnt++;
    if (win_valid) win_cnt++;
    if (write_fifo && px < PRE) fill_w++;
    @(posedge clk);
    pv = er;
    prow = wr;
    pcol = wc;
    if (fl) fl = 0;
    else if (running) begin
      if (ei && iv) n_words++;
      if (er) begin
        n_win++;
        if (n_win == WINS) begin
          running = 0;
          fl = 1;
        end
      end
    end else if (st) begin
      running = 1;
      n_words = 0;
      n_win = 0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    in_valid = 1;
    conv_ready = 1;
    start = 0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_write", write_fifo, 0);
    chk("rst_read", read_fifo, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_pos", {win_row, win_col}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_state", dut.state, 0);
    chk("rst_counters", {dut.wr_px, dut.u_pos.anchor}, 0);
    @(negedge clk);
    resetn = 1;
    running = 0;
    fl = 0;
    pv = 0;
    n_words = 0;
    n_win = 0;
  endtask
  // mode: 0 free-running, 1 random, 2 backpressure, 3 starved input, 4 abort after 7 windows
  task automatic frame(input int mode);
    int cyc = 0, hold = 0;
    bit iv, cr, st;
    wr_cnt = 0;
    win_cnt = 0;
    fill_w = 0;
    step(1, 1, 1);
    while ((running || fl) && cyc < 400) begin
      iv = 1;
      cr = 1;
      st = 0;
      if (mode == 1 || mode == 4) begin
        iv = $urandom % 4 != 0;
        cr = $urandom % 3 != 0;
        st = $urandom % 8 == 0;
      end
      if (mode == 2 && n_win == 5 && hold < 5) begin
        cr = 0;
        hold++;
      end
      if (mode == 3 && n_words >= 4 && hold < 8) begin
        iv = 0;
        hold++;
      end
      if (mode == 4 && n_win == 7) break;
      step(iv, cr, st);
      cyc++;
    end
    chk("timeout", cyc < 400, 1);
    if (mode == 4) do_reset();
    else begin
      chk("frame_writes", wr_cnt, WORDS);
      chk("frame_windows", win_cnt, WINS);
      chk("fill_words", fill_w, 4);
      for (int i = 0; i < 3; i++) step(1, 1, 0);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    do_reset();
    frame(0);
    frame(2);
    frame(3);
    frame(1);
    frame(4);
    frame(0);
    frame(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
